// File: rtl/mag_frame_averager.sv
// mag_frame_averager: averages 2^LOG2_AVG four-channel magnitude frames.
// Optional round-half-up: define MAG_FRAME_AVERAGER_ROUND_EN.
module mag_frame_averager #(
  parameter int MAG_WIDTH   = 26,
  parameter int TUSER_WIDTH = 6,
  parameter int LOG2_AVG    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MAG_WIDTH-1:0]     S_TDATA,
  input  logic [TUSER_WIDTH-1:0]   S_TUSER,
  input  logic                     S_TVALID,
  input  logic                     S_OVERFLOW,
  output logic [4*MAG_WIDTH-1:0]   M_TDATA,
  output logic [TUSER_WIDTH-3:0]   M_TUSER,
  output logic                     M_TVALID,
  output logic [3:0]               M_OVERFLOW,
  output logic                     M_SEQ_ERR
);

  localparam int AW  = MAG_WIDTH + LOG2_AVG;
  localparam int TGW = TUSER_WIDTH - 2;
  localparam int CW  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << LOG2_AVG) - 1);
`ifdef MAG_FRAME_AVERAGER_ROUND_EN
  localparam logic [AW-1:0] RND = AW'((1 << LOG2_AVG) / 2);
`else
  localparam logic [AW-1:0] RND = '0;
`endif

  typedef enum logic {ST_SYNC, ST_ACCUM} state_t;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [AW-1:0]          r_acc [4];
  logic [CW-1:0]          r_cnt;
  logic [1:0]             r_exp;
  logic [TGW-1:0]         r_tag;
  logic [3:0]             r_ovf;
  logic [4*MAG_WIDTH-1:0] r_m_tdata;
  logic [TGW-1:0]         r_m_tuser;
  logic                   r_m_tvalid;
  logic [3:0]             r_m_ovf;
  logic                   r_m_seq_err;

  logic [1:0]             w_ch;
  logic [TGW-1:0]         w_tag;
  logic [AW-1:0]          w_add;
  logic                   w_match;
  logic                   w_seq_err;
  logic                   w_load;
  logic                   w_acc;
  logic                   w_end;
  logic [AW-1:0]          w_sum [4];
  logic [4*MAG_WIDTH-1:0] w_avg;

  assign w_ch  = S_TUSER[1:0];
  assign w_tag = S_TUSER[TUSER_WIDTH-1:2];
  assign w_add = AW'(S_TDATA);

  // Frame-opening channel-0 beats skip the tag check.
  assign w_match   = (w_ch == r_exp) &&
                     ((r_exp == 2'd0) || (w_tag == r_tag));
  assign w_seq_err = S_TVALID && (r_state == ST_ACCUM) && !w_match;
  assign w_load    = S_TVALID && (w_ch == 2'd0) &&
                     ((r_state == ST_SYNC) || w_seq_err);
  assign w_acc     = S_TVALID && (r_state == ST_ACCUM) && w_match;
  assign w_end     = w_acc && (w_ch == 2'd3) && (r_cnt == CNT_MAX);

  // Final window sums, folding in the closing channel-3 beat.
  always_comb begin
    w_avg = '0;
    for (int n = 0; n < 4; n++) begin
      w_sum[n] = r_acc[n] + RND;
      if (n == 3) w_sum[n] = w_sum[n] + w_add;
      w_avg[n*MAG_WIDTH +: MAG_WIDTH] = w_sum[n][AW-1 -: MAG_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_SYNC;
    else     r_state <= w_state_nx;
  end

  // Next state: lock on channel 0, fall back to SYNC on non-ch0 errors.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_SYNC:  if (w_load) w_state_nx = ST_ACCUM;
      ST_ACCUM: if (w_seq_err && !w_load) w_state_nx = ST_SYNC;
      default:  w_state_nx = ST_SYNC;
    endcase
  end

  // Accumulation, window close and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_acc[i] <= '0;
      r_cnt       <= '0;
      r_exp       <= 2'd0;
      r_tag       <= '0;
      r_ovf       <= 4'd0;
      r_m_tdata   <= '0;
      r_m_tuser   <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_ovf     <= 4'd0;
      r_m_seq_err <= 1'b0;
    end else begin
      r_m_tvalid  <= 1'b0;
      r_m_seq_err <= w_seq_err;
      if (w_load) begin
        for (int i = 1; i < 4; i++) r_acc[i] <= '0;
        r_acc[0] <= w_add;
        r_cnt    <= '0;
        r_ovf    <= {3'b000, S_OVERFLOW};
        r_exp    <= 2'd1;
        r_tag    <= w_tag;
      end else if (w_seq_err) begin
        for (int i = 0; i < 4; i++) r_acc[i] <= '0;
        r_cnt <= '0;
        r_ovf <= 4'd0;
        r_exp <= 2'd0;
      end else if (w_acc) begin
        r_exp <= r_exp + 2'd1;
        if (w_end) begin
          r_m_tdata  <= w_avg;
          r_m_ovf    <= r_ovf | {S_OVERFLOW, 3'b000};
          r_m_tuser  <= r_tag;
          r_m_tvalid <= 1'b1;
          for (int i = 0; i < 4; i++) r_acc[i] <= '0;
          r_cnt <= '0;
          r_ovf <= 4'd0;
        end else begin
          r_acc[w_ch] <= r_acc[w_ch] + w_add;
          r_ovf[w_ch] <= r_ovf[w_ch] | S_OVERFLOW;
          if (w_ch == 2'd3) r_cnt <= r_cnt + CW'(1);
          if (w_ch == 2'd0) r_tag <= w_tag;
        end
      end
    end
  end

  assign M_TDATA    = r_m_tdata;
  assign M_TUSER    = r_m_tuser;
  assign M_TVALID   = r_m_tvalid;
  assign M_OVERFLOW = r_m_ovf;
  assign M_SEQ_ERR  = r_m_seq_err;

endmodule

// File: tb/tb_mag_frame_averager.sv
// tb_mag_frame_averager: randomized self-checking bench with a
// window-level averaging model.
module tb_mag_frame_averager;

  localparam int MW  = 26;
  localparam int TW  = 6;
  localparam int L   = 2;
  localparam int NF  = 1 << L;
  localparam int TGW = TW - 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [MW-1:0]   S_TDATA = '0;
  logic [TW-1:0]   S_TUSER = '0;
  logic            S_TVALID = 1'b0;
  logic            S_OVERFLOW = 1'b0;
  logic [4*MW-1:0] M_TDATA;
  logic [TGW-1:0]  M_TUSER;
  logic            M_TVALID;
  logic [3:0]      M_OVERFLOW;
  logic            M_SEQ_ERR;

  mag_frame_averager #(
    .MAG_WIDTH(MW), .TUSER_WIDTH(TW), .LOG2_AVG(L)
  ) dut (
    .clk(clk), .rst(rst),
    .S_TDATA(S_TDATA), .S_TUSER(S_TUSER),
    .S_TVALID(S_TVALID), .S_OVERFLOW(S_OVERFLOW),
    .M_TDATA(M_TDATA), .M_TUSER(M_TUSER),
    .M_TVALID(M_TVALID), .M_OVERFLOW(M_OVERFLOW),
    .M_SEQ_ERR(M_SEQ_ERR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int seq_cnt = 0;
  logic [4*MW-1:0] q_data [$];
  logic [TGW-1:0]  q_user [$];
  logic [3:0]      q_ovf  [$];
  longint          q_t    [$];

  // Output monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (M_TVALID === 1'b1) begin
      q_data.push_back(M_TDATA);
      q_user.push_back(M_TUSER);
      q_ovf.push_back(M_OVERFLOW);
      q_t.push_back($time);
    end
    if (M_SEQ_ERR === 1'b1) seq_cnt++;
  end

  logic [MW-1:0]  wd [NF][4];
  logic           wo [NF][4];
  logic [TGW-1:0] wt [NF];

  task automatic gen_rand();
    for (int f = 0; f < NF; f++) begin
      wt[f] = TGW'($urandom);
      for (int c = 0; c < 4; c++) begin
        wd[f][c] = MW'($urandom);
        wo[f][c] = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  function automatic logic [4*MW-1:0] model_avg();
    logic [4*MW-1:0] r;
    longint s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      s = 0;
      for (int f = 0; f < NF; f++) s += longint'(wd[f][c]);
`ifdef MAG_FRAME_AVERAGER_ROUND_EN
      s += NF / 2;
`endif
      r[c*MW +: MW] = MW'(s / NF);
    end
    return r;
  endfunction

  function automatic logic [3:0] model_ovf();
    logic [3:0] r;
    r = 4'd0;
    for (int f = 0; f < NF; f++)
      for (int c = 0; c < 4; c++)
        if (wo[f][c]) r[c] = 1'b1;
    return r;
  endfunction

  task automatic beat(input int ch, input logic [TGW-1:0] tg,
                      input logic [MW-1:0] d, input logic o);
    @(negedge clk);
    S_TVALID   = 1'b1;
    S_TUSER    = {tg, 2'(ch)};
    S_TDATA    = d;
    S_OVERFLOW = o;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      S_TVALID   = 1'b0;
      S_OVERFLOW = 1'b0;
    end
  endtask

  task automatic send_window(input bit gaps);
    for (int f = 0; f < NF; f++)
      for (int c = 0; c < 4; c++) begin
        beat(c, wt[f], wd[f][c], wo[f][c]);
        if (gaps && !(f == NF - 1 && c == 3))
          idle($urandom_range(0, 2));
      end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_user.delete();
    q_ovf.delete();
    q_t.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 5;
    if (M_TDATA !== '0) begin
      errors++; $display("FAIL reset_tdata: got %0h expected 0", M_TDATA);
    end
    if (M_TUSER !== '0) begin
      errors++; $display("FAIL reset_tuser: got %0h expected 0", M_TUSER);
    end
    if (M_TVALID !== 1'b0) begin
      errors++; $display("FAIL reset_tvalid: got %b expected 0", M_TVALID);
    end
    if (M_OVERFLOW !== 4'd0) begin
      errors++; $display("FAIL reset_ovf: got %b expected 0", M_OVERFLOW);
    end
    if (M_SEQ_ERR !== 1'b0) begin
      errors++; $display("FAIL reset_seqerr: got %b expected 0", M_SEQ_ERR);
    end
    rst = 1'b0;
  endtask

  task automatic test_truncate();
    logic [4*MW-1:0] exp_d;
    logic [4*MW-1:0] spec_d;
    for (int f = 0; f < NF; f++) begin
      wt[f] = TGW'(5);
      for (int c = 0; c < 4; c++) begin
        wd[f][c] = MW'(100 * (c + 1) + f);
        wo[f][c] = 1'b0;
      end
    end
    exp_d = model_avg();
    spec_d = {MW'(401), MW'(301), MW'(201), MW'(101)};
    send_window(1'b0);
    idle(1);
    checks += 5;
    if (M_TVALID !== 1'b1) begin
      errors++; $display("FAIL trunc_latency: got %b expected 1", M_TVALID);
    end
    if (M_TDATA !== exp_d) begin
      errors++; $display("FAIL trunc_data: got %0h expected %0h", M_TDATA, exp_d);
    end
    if (M_TDATA !== spec_d) begin
      errors++; $display("FAIL trunc_const: got %0h expected %0h", M_TDATA, spec_d);
    end
    if (M_TUSER !== TGW'(5)) begin
      errors++; $display("FAIL trunc_tuser: got %0h expected 5", M_TUSER);
    end
    if (M_OVERFLOW !== 4'd0) begin
      errors++; $display("FAIL trunc_ovf: got %b expected 0", M_OVERFLOW);
    end
    idle(1);
    checks += 2;
    if (M_TVALID !== 1'b0) begin
      errors++; $display("FAIL trunc_strobe_len: got %b expected 0", M_TVALID);
    end
    if (M_TDATA !== exp_d) begin
      errors++; $display("FAIL trunc_hold: got %0h expected %0h", M_TDATA, exp_d);
    end
  endtask

  task automatic test_round();
    logic [4*MW-1:0] exp_d;
    logic [MW-1:0] exp_c0;
    gen_rand();
    wd[0][0] = MW'(1);
    wd[1][0] = MW'(2);
    wd[2][0] = MW'(2);
    wd[3][0] = MW'(2);
    exp_d = model_avg();
`ifdef MAG_FRAME_AVERAGER_ROUND_EN
    exp_c0 = MW'(2);
`else
    exp_c0 = MW'(1);
`endif
    send_window(1'b1);
    idle(1);
    checks += 3;
    if (M_TVALID !== 1'b1) begin
      errors++; $display("FAIL round_valid: got %b expected 1", M_TVALID);
    end
    if (M_TDATA !== exp_d) begin
      errors++; $display("FAIL round_data: got %0h expected %0h", M_TDATA, exp_d);
    end
    if (M_TDATA[MW-1:0] !== exp_c0) begin
      errors++;
      $display("FAIL round_ch0: got %0d expected %0d", M_TDATA[MW-1:0], exp_c0);
    end
  endtask

  task automatic test_seq_err();
    logic [4*MW-1:0] exp_d;
    logic [TGW-1:0] tg;
    int s0;
    idle(2);
    clear_q();
    s0 = seq_cnt;
    beat(0, 3, MW'(11), 1'b0);
    beat(1, 3, MW'(22), 1'b0);
    beat(3, 3, MW'(33), 1'b0);
    idle(1);
    checks++;
    if (M_SEQ_ERR !== 1'b1) begin
      errors++; $display("FAIL seq_pulse: got %b expected 1", M_SEQ_ERR);
    end
    idle(1);
    checks += 2;
    if (M_SEQ_ERR !== 1'b0) begin
      errors++; $display("FAIL seq_pulse_len: got %b expected 0", M_SEQ_ERR);
    end
    if (q_data.size() != 0) begin
      errors++; $display("FAIL seq_no_valid: got %0d strobes expected 0", q_data.size());
    end
    gen_rand();
    exp_d = model_avg();
    send_window(1'b0);
    idle(1);
    checks += 2;
    if (M_TDATA !== exp_d) begin
      errors++; $display("FAIL seq_clean_data: got %0h expected %0h", M_TDATA, exp_d);
    end
    if (M_TUSER !== wt[NF-1]) begin
      errors++; $display("FAIL seq_clean_tuser: got %0h expected %0h", M_TUSER, wt[NF-1]);
    end
    tg = TGW'($urandom);
    beat(0, tg, MW'($urandom), 1'b0);
    beat(1, tg ^ TGW'(1), MW'($urandom), 1'b0);
    beat(0, tg, MW'($urandom), 1'b0);
    beat(1, tg, MW'($urandom), 1'b0);
    gen_rand();
    exp_d = model_avg();
    send_window(1'b0);
    idle(1);
    checks += 3;
    if (M_TVALID !== 1'b1) begin
      errors++; $display("FAIL restart_valid: got %b expected 1", M_TVALID);
    end
    if (M_TDATA !== exp_d) begin
      errors++; $display("FAIL restart_data: got %0h expected %0h", M_TDATA, exp_d);
    end
    if (seq_cnt - s0 != 3) begin
      errors++; $display("FAIL seq_count: got %0d expected 3", seq_cnt - s0);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] exp_o;
    gen_rand();
    for (int f = 0; f < NF; f++)
      for (int c = 0; c < 4; c++) wo[f][c] = 1'b0;
    wo[1][2] = 1'b1;
    exp_o = model_ovf();
    send_window(1'b0);
    idle(1);
    checks += 2;
    if (M_OVERFLOW !== exp_o) begin
      errors++; $display("FAIL ovf_model: got %b expected %b", M_OVERFLOW, exp_o);
    end
    if (M_OVERFLOW !== 4'b0100) begin
      errors++; $display("FAIL ovf_ch2: got %b expected 0100", M_OVERFLOW);
    end
    gen_rand();
    for (int f = 0; f < NF; f++)
      for (int c = 0; c < 4; c++) wo[f][c] = 1'b0;
    send_window(1'b1);
    idle(1);
    checks++;
    if (M_OVERFLOW !== 4'b0000) begin
      errors++; $display("FAIL ovf_next: got %b expected 0000", M_OVERFLOW);
    end
  endtask

  task automatic run_windows(input int nw, input bit gaps, input string nm);
    logic [4*MW-1:0] e_d [$];
    logic [TGW-1:0]  e_u [$];
    logic [3:0]      e_o [$];
    int s0;
    idle(2);
    clear_q();
    s0 = seq_cnt;
    for (int w = 0; w < nw; w++) begin
      gen_rand();
      e_d.push_back(model_avg());
      e_u.push_back(wt[NF-1]);
      e_o.push_back(model_ovf());
      send_window(gaps);
    end
    idle(3);
    checks += 2;
    if (q_data.size() != nw) begin
      errors++;
      $display("FAIL %s_count: got %0d strobes expected %0d", nm, q_data.size(), nw);
    end
    if (seq_cnt != s0) begin
      errors++; $display("FAIL %s_seqerr: got %0d expected 0", nm, seq_cnt - s0);
    end
    for (int w = 0; w < nw && w < q_data.size(); w++) begin
      checks += 3;
      if (q_data[w] !== e_d[w]) begin
        errors++;
        $display("FAIL %s_data%0d: got %0h expected %0h", nm, w, q_data[w], e_d[w]);
      end
      if (q_user[w] !== e_u[w]) begin
        errors++;
        $display("FAIL %s_tuser%0d: got %0h expected %0h", nm, w, q_user[w], e_u[w]);
      end
      if (q_ovf[w] !== e_o[w]) begin
        errors++;
        $display("FAIL %s_ovf%0d: got %b expected %b", nm, w, q_ovf[w], e_o[w]);
      end
      if (!gaps && w > 0) begin
        checks++;
        if (q_t[w] - q_t[w-1] != 160) begin
          errors++;
          $display("FAIL %s_spacing%0d: got %0d expected 160",
                   nm, w, q_t[w] - q_t[w-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_windows(3, 1'b0, "b2b");
  endtask

  task automatic test_gaps();
    run_windows(2, 1'b1, "gaps");
  endtask

  task automatic test_async_reset();
    logic [4*MW-1:0] exp_d;
    logic [TGW-1:0] tg;
    int s0;
    gen_rand();
    send_window(1'b0);
    idle(1);
    tg = TGW'($urandom);
    beat(0, tg, MW'($urandom), 1'b1);
    beat(1, tg, MW'($urandom), 1'b1);
    @(negedge clk);
    S_TVALID = 1'b0;
    S_OVERFLOW = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (M_TDATA !== '0) begin
      errors++; $display("FAIL arst_tdata: got %0h expected 0", M_TDATA);
    end
    if (M_TUSER !== '0) begin
      errors++; $display("FAIL arst_tuser: got %0h expected 0", M_TUSER);
    end
    if (M_TVALID !== 1'b0) begin
      errors++; $display("FAIL arst_tvalid: got %b expected 0", M_TVALID);
    end
    if (M_OVERFLOW !== 4'd0) begin
      errors++; $display("FAIL arst_ovf: got %b expected 0", M_OVERFLOW);
    end
    if (M_SEQ_ERR !== 1'b0) begin
      errors++; $display("FAIL arst_seqerr: got %b expected 0", M_SEQ_ERR);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    clear_q();
    s0 = seq_cnt;
    beat(2, tg, MW'($urandom), 1'b1);
    beat(3, tg, MW'($urandom), 1'b1);
    idle(2);
    gen_rand();
    for (int f = 0; f < NF; f++)
      for (int c = 0; c < 4; c++) wo[f][c] = 1'b0;
    exp_d = model_avg();
    send_window(1'b1);
    idle(2);
    checks += 4;
    if (q_data.size() != 1) begin
      errors++; $display("FAIL arst_count: got %0d strobes expected 1", q_data.size());
    end else if (q_data[0] !== exp_d) begin
      errors++; $display("FAIL arst_data: got %0h expected %0h", q_data[0], exp_d);
    end
    if (M_OVERFLOW !== 4'd0) begin
      errors++; $display("FAIL arst_ovf_win: got %b expected 0", M_OVERFLOW);
    end
    if (M_TUSER !== wt[NF-1]) begin
      errors++; $display("FAIL arst_tuser_win: got %0h expected %0h", M_TUSER, wt[NF-1]);
    end
    if (seq_cnt != s0) begin
      errors++; $display("FAIL arst_seqerr_win: got %0d expected 0", seq_cnt - s0);
    end
  endtask

  initial begin
    test_reset();
    test_truncate();
    test_round();
    test_seq_err();
    test_overflow();
    test_back_to_back();
    test_gaps();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
